// File: rtl/bt_cmd_arb_pkg.sv
// Shared types and constants for the command arbiter: FSM state encoding,
// command field widths and the round-robin pointer wrap helper.
package bt_pkg;

  localparam int CMD_START_W = 5;
  localparam int CMD_LEN_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Index that follows idx in a ring of n requesters.
  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    int unsigned v_nxt;
    if (idx + 32'd1 >= n) begin
      v_nxt = 32'd0;
    end else begin
      v_nxt = idx + 32'd1;
    end
    return v_nxt;
  endfunction

endpackage

// File: rtl/bt_cmd_arb_if.sv
// Requester/command-sender bus of the command arbiter. The environment
// (requesters plus command sender) uses the master view, the arbiter the
// slave view.
interface bt_cmd_arb_if #(
  parameter int unsigned NREQ = 3
) ();
  import bt_pkg::*;

  logic [NREQ-1:0]                   req;
  logic [NREQ-1:0][CMD_START_W-1:0]  req_start;
  logic [NREQ-1:0][CMD_LEN_W-1:0]    req_len;
  logic [NREQ-1:0]                   gnt;
  logic [NREQ-1:0]                   done;
  logic [NREQ-1:0]                   err;
  logic                              busy;
  logic                              send;
  logic [CMD_START_W-1:0]            cmd_start;
  logic [CMD_LEN_W-1:0]              cmd_len;
  logic                              resp_rcvd;

  modport master (
    output req, req_start, req_len, resp_rcvd,
    input  gnt, done, err, busy, send, cmd_start, cmd_len
  );

  modport slave (
    input  req, req_start, req_len, resp_rcvd,
    output gnt, done, err, busy, send, cmd_start, cmd_len
  );

endinterface

// File: rtl/bt_cmd_arb_rr_arb.sv
// Round-robin selector: scans the request vector starting at the pointer,
// wrapping once, and returns the first active requester as a one-hot grant
// together with its index.
module rr_arb #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_valid,
  output logic [PTR_W-1:0] o_idx
);

  // First requester at or after the pointer (modulo NREQ) wins.
  always_comb begin
    int unsigned      v_pos;
    logic [PTR_W-1:0] v_idx;
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    v_pos   = 32'd0;
    v_idx   = '0;
    for (int unsigned off = 32'd0; off < NREQ; off++) begin
      v_pos = 32'(i_ptr) + off;
      if (v_pos >= NREQ) begin
        v_pos = v_pos - NREQ;
      end else begin
        v_pos = v_pos;
      end
      v_idx = PTR_W'(v_pos);
      if (!o_valid && i_req[v_idx]) begin
        o_valid      = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_idx        = v_idx;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/bt_cmd_arb.sv
// Command arbiter: shares one command sender among NREQ requesters.
// IDLE picks a round-robin winner and captures its command, ISSUE pulses
// send once, WAIT watches for the response with a timeout and re-sends up
// to MAX_RETRY times before abandoning the command with err.
module bt_cmd_arb #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned TIMEOUT_CYC = 32'h0001_FFFF,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  bt_cmd_arb_if.slave bus
);
  import bt_pkg::*;

  localparam int unsigned PTR_W = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC + 32'd1) : 32'd1;
  localparam int unsigned RTY_W = (MAX_RETRY > 32'd0) ? $clog2(MAX_RETRY + 32'd1) : 32'd1;

  state_e                  r_state;
  logic [PTR_W-1:0]        r_ptr;
  logic [RTY_W-1:0]        r_retry;
  logic [CNT_W-1:0]        r_cnt;
  logic [NREQ-1:0]         r_owner;
  logic [NREQ-1:0]         r_gnt;
  logic [NREQ-1:0]         r_done;
  logic [NREQ-1:0]         r_err;
  logic                    r_send;
  logic                    r_busy;
  logic [CMD_START_W-1:0]  r_cmd_start;
  logic [CMD_LEN_W-1:0]    r_cmd_len;

  logic [NREQ-1:0]         w_req_m;
  logic [NREQ-1:0]         w_win;
  logic                    w_valid;
  logic [PTR_W-1:0]        w_idx;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic                    w_len_zero;
  logic                    w_timeout;
  logic                    w_retry_ok;

  // A requester granted last cycle cannot have dropped req yet (gnt is
  // registered), so it is hidden for one cycle to avoid a double grant
  // after a zero-length command.
  assign w_req_m = bus.req & ~r_gnt;

  rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .i_req   (w_req_m),
    .i_ptr   (r_ptr),
    .o_gnt   (w_win),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_ptr_nxt  = PTR_W'(rr_next_idx(32'(w_idx), NREQ));
  assign w_len_zero = (bus.req_len[w_idx] == {CMD_LEN_W{1'b0}});
  // The counter "reaches 0" on the WAIT cycle that would decrement it to 0,
  // which gives a TIMEOUT_CYC+1 cycle send-to-send period across retries.
  assign w_timeout  = (r_cnt <= CNT_W'(32'd1));
  assign w_retry_ok = (32'(r_retry) < MAX_RETRY);

  // Arbitration / issue / wait FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_owner     <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_send      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_start <= '0;
      r_cmd_len   <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_gnt <= w_win;
            r_ptr <= w_ptr_nxt;
            if (w_len_zero) begin
              // Nothing to send: refuse the command but keep the turn order.
              r_err <= w_win;
            end else begin
              r_owner     <= w_win;
              r_cmd_start <= bus.req_start[w_idx];
              r_cmd_len   <= bus.req_len[w_idx];
              r_retry     <= '0;
              r_busy      <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_send  <= 1'b1;
          r_cnt   <= CNT_W'(TIMEOUT_CYC);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.resp_rcvd) begin
            // A response wins over a simultaneous timeout.
            r_done  <= r_owner;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_cnt <= '0;
            if (w_retry_ok) begin
              r_retry <= r_retry + RTY_W'(32'd1);
              r_state <= ST_ISSUE;
            end else begin
              r_err   <= r_owner;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(32'd1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
  assign bus.send      = r_send;
  assign bus.cmd_start = r_cmd_start;
  assign bus.cmd_len   = r_cmd_len;

endmodule

// File: tb/tb_bt_cmd_arb.sv
// Bench for bt_cmd_arb: reset checks, a long-timeout single command, a table
// of single-command transactions, a mid-WAIT reset sequence and a random run
// against a schedule-based reference model.
module tb_bt_cmd_arb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bt_cmd_arb_if #(.NREQ(3)) bus   ();
  bt_cmd_arb_if #(.NREQ(3)) bus_a ();

  bt_cmd_arb #(.NREQ(3), .TIMEOUT_CYC(10), .MAX_RETRY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bt_cmd_arb #(.NREQ(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [3:0] len;
    int         att;       // send attempt that gets answered, 3 = never
    int         k;         // response cycle offset from that send (0..9)
    logic [2:0] exp_gnt;
    int         exp_nsend;
    logic [2:0] exp_done;
    logic [2:0] exp_err;
  } vec_t;

  vec_t tbl [9];

  localparam int NRND  = 1500;
  localparam int ASIZE = 2048;

  logic [2:0] exp_gnt  [ASIZE];
  logic [2:0] exp_done [ASIZE];
  logic [2:0] exp_err  [ASIZE];
  logic       exp_send [ASIZE];
  logic       exp_busy [ASIZE];
  logic [4:0] exp_start[ASIZE];
  logic [3:0] exp_len  [ASIZE];
  logic       plan_resp[ASIZE];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    int r;
    r = 0;
    for (int i = 2; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] outs_dut();
    return {8'h0, bus.gnt, bus.done, bus.err, bus.busy, bus.send, bus.cmd_start, bus.cmd_len};
  endfunction

  task automatic run_row(input int r);
    logic [2:0] g_seen, d_seen, e_seen;
    int n_send, gnt_c, last_send, done_c, err_c, nd, ne, widx, exp_c;
    bit busy_seen, spacing_ok, fields_ok;
    g_seen = '0; d_seen = '0; e_seen = '0;
    n_send = 0; gnt_c = -1; last_send = -1; done_c = -1; err_c = -1; nd = 0; ne = 0;
    busy_seen = 1'b0; spacing_ok = 1'b1; fields_ok = 1'b1;
    widx = oh_idx(tbl[r].exp_gnt);
    for (int i = 0; i < 3; i++) begin
      bus.req_start[i] = 5'(i * 7 + r);
      bus.req_len[i]   = tbl[r].len;
    end
    bus.req = tbl[r].req;
    for (int c = 0; c < 60; c++) begin
      tick();
      bus.resp_rcvd = 1'b0;
      if (bus.gnt != 3'b000) begin
        g_seen |= bus.gnt;
        gnt_c = c;
        bus.req = 3'b000;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.send) begin
        exp_c = (n_send == 0) ? gnt_c + 1 : last_send + 11;
        if (c != exp_c) spacing_ok = 1'b0;
        if (bus.cmd_start != 5'(widx * 7 + r) || bus.cmd_len != tbl[r].len) fields_ok = 1'b0;
        last_send = c;
        n_send++;
      end
      if (bus.done != 3'b000) begin d_seen |= bus.done; nd++; done_c = c; end
      if (bus.err != 3'b000) begin e_seen |= bus.err; ne++; err_c = c; end
      if (last_send >= 0 && n_send - 1 == tbl[r].att && c == last_send + tbl[r].k)
        bus.resp_rcvd = 1'b1;
    end
    bus.resp_rcvd = 1'b0;
    check($sformatf("row%0d_gnt", r), 32'(g_seen), 32'(tbl[r].exp_gnt));
    check($sformatf("row%0d_nsend", r), n_send, tbl[r].exp_nsend);
    check($sformatf("row%0d_done", r), 32'(d_seen), 32'(tbl[r].exp_done));
    check($sformatf("row%0d_err", r), 32'(e_seen), 32'(tbl[r].exp_err));
    check($sformatf("row%0d_pulses", r), nd + ne, 1);
    if (tbl[r].exp_nsend > 0) begin
      check($sformatf("row%0d_spacing", r), 32'(spacing_ok), 32'd1);
      check($sformatf("row%0d_fields", r), 32'(fields_ok), 32'd1);
    end
    if (tbl[r].exp_done != 3'b000)
      check($sformatf("row%0d_done_lat", r), done_c, last_send + tbl[r].k + 1);
    if (tbl[r].exp_err != 3'b000 && tbl[r].exp_nsend > 0)
      check($sformatf("row%0d_err_lat", r), err_c, last_send + 10);
    if (tbl[r].exp_nsend == 0) begin
      check($sformatf("row%0d_len0_same", r), err_c, gnt_c);
      check($sformatf("row%0d_len0_busy", r), 32'(busy_seen), 32'd0);
    end
  endtask

  initial begin
    int s_cyc;
    bit early, seen;
    logic [2:0] acc;
    logic [2:0] rq;
    logic [4:0] st [3];
    logic [3:0] ln [3];
    int m_last, m_free, w, att, k, end_c, s;
    bit got, stray_ok, found;
    logic [2:0] oh;

    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{3'b001, 4'd6,  0, 3, 3'b001, 1, 3'b001, 3'b000};
    tbl[1] = '{3'b111, 4'd6,  0, 0, 3'b010, 1, 3'b010, 3'b000};
    tbl[2] = '{3'b111, 4'd2,  0, 5, 3'b100, 1, 3'b100, 3'b000};
    tbl[3] = '{3'b111, 4'd15, 0, 1, 3'b001, 1, 3'b001, 3'b000};
    tbl[4] = '{3'b001, 4'd6,  3, 0, 3'b001, 3, 3'b000, 3'b001};
    tbl[5] = '{3'b101, 4'd9,  0, 9, 3'b100, 1, 3'b100, 3'b000};
    tbl[6] = '{3'b010, 4'd0,  3, 0, 3'b010, 0, 3'b000, 3'b010};
    tbl[7] = '{3'b011, 4'd3,  1, 5, 3'b001, 2, 3'b001, 3'b000};
    tbl[8] = '{3'b011, 4'd8,  2, 9, 3'b010, 3, 3'b010, 3'b000};

    bus.req = '0; bus.req_start = '0; bus.req_len = '0; bus.resp_rcvd = 1'b0;
    bus_a.req = '0; bus_a.req_start = '0; bus_a.req_len = '0; bus_a.resp_rcvd = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check("reset_outs", outs_dut(), 32'd0);
    check("reset_outs_a", {8'h0, bus_a.gnt, bus_a.done, bus_a.err, bus_a.busy, bus_a.send,
                           bus_a.cmd_start, bus_a.cmd_len}, 32'd0);
    rst = 1'b0;

    // Single command, response 20 cycles after send (long-timeout instance)
    bus_a.req_start[0] = 5'd0;
    bus_a.req_len[0]   = 4'd6;
    bus_a.req          = 3'b001;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!seen) begin
        tick();
        if (bus_a.gnt != 3'b000) seen = 1'b1;
      end
    end
    check("a_gnt", 32'(bus_a.gnt), 32'b001);
    bus_a.req = 3'b000;
    tick();
    check("a_send", {bus_a.send, bus_a.cmd_start, bus_a.cmd_len}, {1'b1, 5'd0, 4'd6});
    early = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (bus_a.done != 3'b000 || bus_a.err != 3'b000 || bus_a.send) early = 1'b1;
    end
    check("a_quiet_wait", 32'(early), 32'd0);
    bus_a.resp_rcvd = 1'b1;
    tick();
    bus_a.resp_rcvd = 1'b0;
    check("a_done", 32'(bus_a.done), 32'b001);
    tick();
    check("a_idle", 32'(bus_a.busy), 32'd0);

    // Table of single-command transactions
    for (int r = 0; r < 9; r++) run_row(r);

    // Reset while waiting for a response
    bus.req_start[0] = 5'd3;
    bus.req_len[0]   = 4'd5;
    bus.req          = 3'b001;
    tick();
    check("rst_pre_gnt", 32'(bus.gnt), 32'b001);
    bus.req = 3'b000;
    tick(); tick(); tick();
    check("rst_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_immediate", outs_dut(), 32'd0);
    tick(); tick();
    rst = 1'b0;
    bus.resp_rcvd = 1'b1;
    tick();
    bus.resp_rcvd = 1'b0;
    acc = 3'b000;
    early = 1'b0;
    for (int j = 0; j < 15; j++) begin
      acc |= bus.done | bus.err;
      if (bus.busy || bus.send) early = 1'b1;
      tick();
    end
    check("rst_no_done_err", 32'(acc), 32'd0);
    check("rst_quiet", 32'(early), 32'd0);
    bus.req_len[1] = 4'd4;
    bus.req = 3'b011;
    tick();
    check("rst_ptr_zero", 32'(bus.gnt), 32'b001);
    bus.req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random traffic against the schedule model
    for (int i = 0; i < ASIZE; i++) begin
      exp_gnt[i] = '0; exp_done[i] = '0; exp_err[i] = '0; exp_send[i] = 1'b0;
      exp_busy[i] = 1'b0; exp_start[i] = '0; exp_len[i] = '0; plan_resp[i] = 1'b0;
    end
    rq = 3'b000;
    for (int i = 0; i < 3; i++) begin st[i] = 5'd0; ln[i] = 4'd0; end
    m_last = 2;
    m_free = 0;
    for (int t = 0; t < NRND + 40; t++) begin
      check("rnd_gnt",  32'(bus.gnt),  32'(exp_gnt[t]));
      check("rnd_done", 32'(bus.done), 32'(exp_done[t]));
      check("rnd_err",  32'(bus.err),  32'(exp_err[t]));
      check("rnd_send", 32'(bus.send), 32'(exp_send[t]));
      check("rnd_busy", 32'(bus.busy), 32'(exp_busy[t]));
      if (exp_busy[t])
        check("rnd_cmd", {bus.cmd_start, bus.cmd_len}, {exp_start[t], exp_len[t]});

      for (int i = 0; i < 3; i++) begin
        if (exp_gnt[t][i]) begin
          rq[i] = 1'b0;
        end else if (!rq[i] && t < NRND && $urandom_range(0, 5) == 0) begin
          rq[i] = 1'b1;
          st[i] = 5'($urandom);
          ln[i] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end else if (rq[i] && $urandom_range(0, 39) == 0) begin
          rq[i] = 1'b0;
        end
        bus.req_start[i] = st[i];
        bus.req_len[i]   = ln[i];
      end
      bus.req = rq;

      stray_ok = (t >= m_free);
      if (t >= m_free && rq != 3'b000) begin
        found = 1'b0;
        w = 0;
        for (int j = 1; j <= 3; j++) begin
          if (!found && rq[(m_last + j) % 3]) begin
            found = 1'b1;
            w = (m_last + j) % 3;
          end
        end
        m_last = w;
        oh = 3'b001 << w;
        exp_gnt[t + 1] = oh;
        if (ln[w] == 4'd0) begin
          exp_err[t + 1] = oh;
          m_free = t + 1;
        end else begin
          att = $urandom_range(0, 3);
          k = $urandom_range(0, 9);
          end_c = t + 34;
          got = 1'b0;
          for (int j = 0; j < 3; j++) begin
            if (!got) begin
              s = t + 2 + 11 * j;
              exp_send[s] = 1'b1;
              if (j == att) begin
                plan_resp[s + k] = 1'b1;
                end_c = s + k + 1;
                got = 1'b1;
              end
            end
          end
          if (got) exp_done[end_c] = oh;
          else     exp_err[end_c]  = oh;
          for (int c = t + 1; c < end_c; c++) begin
            exp_busy[c]  = 1'b1;
            exp_start[c] = st[w];
            exp_len[c]   = ln[w];
          end
          m_free = end_c;
        end
      end

      bus.resp_rcvd = plan_resp[t] | (stray_ok && $urandom_range(0, 9) == 0);
      tick();
    end
    bus.req = 3'b000;
    bus.resp_rcvd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bt_cmd_arb.md
BT_CMD_ARB -- requirements
Module: bt_cmd_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the command sender.
REQ-002 Parameter TIMEOUT_CYC, default 17'h1FFFF: cycles to wait for resp_rcvd before a command is treated as lost.
REQ-003 Parameter MAX_RETRY, default 2: re-sends allowed after the first timeout, before reporting an error.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request level; held with its cmd fields until gnt.
REQ-007 req_start  input  NREQ x 5  per-requester command-ROM start address.
REQ-008 req_len  input  NREQ x 4  per-requester command length in bytes.
REQ-009 gnt  output  NREQ  one-cycle pulse: request accepted, fields captured.
REQ-010 done  output  NREQ  one-cycle pulse: response received for that requester's command.
REQ-011 err  output  NREQ  one-cycle pulse: command abandoned (retries exhausted or req_len==0).
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 send  output  1  one-cycle pulse to command sender.
REQ-014 cmd_start  output  5  registered start address to command sender.
REQ-015 cmd_len  output  4  registered length to command sender.
REQ-016 resp_rcvd  input  1  one-cycle pulse from command sender when the response has arrived.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT; at most one command SHALL be outstanding.
REQ-018 IDLE: if any req is high, the round-robin winner SHALL be chosen, starting from the index after the last granted requester (index 0 after reset).
REQ-019 On a win, gnt[winner] SHALL pulse in that IDLE cycle, req_start/req_len SHALL be registered into cmd_start/cmd_len, retry count SHALL clear, and next state SHALL be ISSUE.
REQ-020 Winner with req_len==0: gnt and err SHALL pulse together, no send SHALL occur, state SHALL stay IDLE, and the pointer SHALL advance.
REQ-021 ISSUE: send SHALL be high for exactly one cycle, the timeout counter SHALL load TIMEOUT_CYC, and next state SHALL be WAIT; send latency from gnt SHALL be 1 cycle.
REQ-022 WAIT: the counter SHALL decrement each cycle; resp_rcvd SHALL pulse done[owner] next cycle and return to IDLE.
REQ-023 WAIT: when the counter reaches 0 with no resp_rcvd, the block SHALL go to ISSUE if retry count < MAX_RETRY (count +1), else pulse err[owner] and return to IDLE.
REQ-024 resp_rcvd and timeout in the same cycle SHALL be treated as a response (done, no retry).
REQ-025 resp_rcvd in IDLE or ISSUE SHALL be ignored.
REQ-026 cmd_start/cmd_len SHALL stay stable from gnt until the block returns to IDLE, including across retries.
REQ-027 New req activity while busy SHALL be ignored until IDLE; a requester deasserting req before gnt SHALL simply lose its turn.
REQ-028 Back-to-back: arbitration SHALL resume in the first IDLE cycle after completion (minimum 3 cycles per command plus response wait).
REQ-029 The pointer SHALL advance only on a grant; done, err and gnt SHALL be mutually exclusive per requester, except the REQ-020 case.

Reset
REQ-030 rst asserted SHALL force, immediately and mid-operation: state IDLE, pointer 0, retry count 0, counter 0, cmd_start 0, cmd_len 0, and send/gnt/done/err/busy all 0.
REQ-031 An outstanding command interrupted by rst SHALL not produce done or err after reset release.

Structure
REQ-032 Package bt_pkg SHALL hold the state enum, CMD_START_W=5, and CMD_LEN_W=4.
REQ-033 Round-robin selection SHALL be a sub-module rr_arb (req, pointer -> one-hot winner, valid).

Verification
REQ-034 req=3'b001, start=0, len=6; resp_rcvd 20 cycles after send -> gnt[0], send next cycle with cmd_start=0, cmd_len=6, then done[0].
REQ-035 req=3'b111 held, each response prompt -> grants in order 0,1,2,0; no requester granted twice in a row.
REQ-036 TIMEOUT_CYC=10, no response -> send pulses 3 times, each 11 cycles apart, then err[owner] once and busy low.
REQ-037 resp_rcvd coincident with counter==0 -> done pulses, no extra send, no err.
REQ-038 req[1] with len=0 -> gnt[1] and err[1] in the same cycle, no send, busy stays 0.
REQ-039 rst pulsed while in WAIT -> all outputs 0 immediately; a later resp_rcvd produces no done.
